// File: rtl/nn_pkg.sv
// Shared definitions for the pointwise-convolution layer scheduler.
// State encoding, pixel-count and log2 helpers.
package nn_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PARAM  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_PARAM  = ST_PARAM,
        S_STREAM = ST_STREAM,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int total_px(input int size);
        return size * size;
    endfunction

endpackage

// File: rtl/pconv_sched_wr.sv
// Write-back side of the scheduler: result capture, write counter,
// drain idle timeout and missing/extra/stray result error flag.
module pconv_sched_wr
    import nn_pkg::*;
#(
    parameter int N              = 16,
    parameter int OUTPUT_CHANNEL = 32,
    parameter int ADDR_W         = 10,
    parameter int TOTAL          = 36,
    parameter int DRAIN_TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        cap_en,
    input  logic                        drain,
    input  logic                        stray_chk,
    input  logic                        dout_vld,
    input  logic [OUTPUT_CHANNEL*N-1:0] dout,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [OUTPUT_CHANNEL*N-1:0] wr_data,
    output logic                        wr_full,
    output logic                        timeout,
    output logic                        err
);

    localparam int IDLE_W = (clog2(DRAIN_TIMEOUT + 1) > 8) ?
                            clog2(DRAIN_TIMEOUT + 1) : 8;
    localparam logic [ADDR_W:0]   TOT = (ADDR_W + 1)'(TOTAL);
    localparam logic [IDLE_W-1:0] TMO = IDLE_W'(DRAIN_TIMEOUT);

    logic [ADDR_W:0]   wr_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              take;
    logic              extra;
    logic              stray;

    assign wr_full = (wr_cnt == TOT);
    assign timeout = drain && (idle_cnt == TMO);
    assign take    = cap_en && dout_vld && !wr_full;
    assign extra   = cap_en && dout_vld && wr_full;
    assign stray   = stray_chk && dout_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_cnt   <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wr_en <= take;
            if (take) begin
                wr_addr <= wr_cnt[ADDR_W-1:0];
                wr_data <= dout;
            end
            if (clr) begin
                wr_cnt   <= '0;
                idle_cnt <= '0;
                err      <= 1'b0;
            end else begin
                if (take) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                // idle count only runs while waiting out the array in DRAIN
                if (!drain || dout_vld) begin
                    idle_cnt <= '0;
                end else if (!timeout) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (extra || stray || timeout) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pconv_sched.sv
// Layer scheduler for the pointwise-convolution array: parameter load,
// feature-map streaming and output-buffer write-back with error checks.
module pconv_sched
    import nn_pkg::*;
#(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 32,
    parameter int INPUT_SIZE     = 6,
    parameter int ADDR_W         = 10,
    parameter int LAYER_W        = 4,
    parameter int DRAIN_TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [LAYER_W-1:0]          layer_id,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        param_req,
    output logic [LAYER_W-1:0]          param_layer,
    input  logic                        param_ack,
    output logic                        fm_rd_en,
    output logic [ADDR_W-1:0]           fm_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0]  fm_rd_data,
    output logic                        pc_input_vld,
    output logic [INPUT_CHANNEL*N-1:0]  pc_input_din,
    input  logic                        pc_dout_vld,
    input  logic [OUTPUT_CHANNEL*N-1:0] pc_dout,
    output logic                        ob_wr_en,
    output logic [ADDR_W-1:0]           ob_wr_addr,
    output logic [OUTPUT_CHANNEL*N-1:0] ob_wr_data
);

    localparam int TOTAL = total_px(INPUT_SIZE);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(TOTAL - 1);

    state_t          state;
    logic [ADDR_W:0] rd_cnt;
    logic            kill;
    logic            accept;
    logic            wr_full;
    logic            timeout;
    logic            cap_en;
    logic            drain;
    logic            stray_chk;

    assign kill         = abort && (state != S_IDLE);
    assign accept       = start && (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign fm_rd_addr   = rd_cnt[ADDR_W-1:0];
    assign pc_input_din = fm_rd_data;

    // abort suppresses every capture/error path in the cycle it lands
    assign cap_en    = !kill && ((state == S_STREAM) || (state == S_DRAIN));
    assign drain     = !kill && (state == S_DRAIN);
    assign stray_chk = !kill && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rd_cnt       <= '0;
            param_req    <= 1'b0;
            param_layer  <= '0;
            fm_rd_en     <= 1'b0;
            pc_input_vld <= 1'b0;
            done         <= 1'b0;
        end else begin
            pc_input_vld <= fm_rd_en;
            done         <= 1'b0;
            if (kill) begin
                state     <= S_IDLE;
                param_req <= 1'b0;
                fm_rd_en  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            param_layer <= layer_id;
                            rd_cnt      <= '0;
                            param_req   <= 1'b1;
                            state       <= S_PARAM;
                        end
                    end
                    S_PARAM: begin
                        if (param_ack) begin
                            param_req <= 1'b0;
                            fm_rd_en  <= 1'b1;
                            state     <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) begin
                            fm_rd_en <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (wr_full || timeout) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    pconv_sched_wr #(
        .N             (N),
        .OUTPUT_CHANNEL(OUTPUT_CHANNEL),
        .ADDR_W        (ADDR_W),
        .TOTAL         (TOTAL),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .cap_en   (cap_en),
        .drain    (drain),
        .stray_chk(stray_chk),
        .dout_vld (pc_dout_vld),
        .dout     (pc_dout),
        .wr_en    (ob_wr_en),
        .wr_addr  (ob_wr_addr),
        .wr_data  (ob_wr_data),
        .wr_full  (wr_full),
        .timeout  (timeout),
        .err      (err)
    );

endmodule

// File: tb/tb_pconv_sched.sv
// Directed bench for pconv_sched with a RAM model and a latency-4
// array model whose result stream can be gapped, truncated or padded.
module tb_pconv_sched;

    localparam int TOTAL = 36;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   layer_id = '0;
    logic         param_ack = 1'b0;
    logic [47:0]  fm_rd_data = '0;
    logic         pc_dout_vld = 1'b0;
    logic [511:0] pc_dout = '0;

    logic         busy;
    logic         done;
    logic         err;
    logic         param_req;
    logic [3:0]   param_layer;
    logic         fm_rd_en;
    logic [9:0]   fm_rd_addr;
    logic         pc_input_vld;
    logic [47:0]  pc_input_din;
    logic         ob_wr_en;
    logic [9:0]   ob_wr_addr;
    logic [511:0] ob_wr_data;

    int total = 0;
    int bad = 0;

    int           rd_q[$];
    int           wa_q[$];
    logic [511:0] wd_q[$];
    int           rq[$];
    int           in_idx = 0;
    int           in_runs = 0;
    int           in_bad = 0;
    int           done_cnt = 0;
    int           mode = 0;
    int           gap_ph = 0;
    bit           prev_vld = 1'b0;
    bit           pipe_v[4];
    int           pipe_idx[4];

    pconv_sched #(
        .N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(32), .INPUT_SIZE(6),
        .ADDR_W(10), .LAYER_W(4), .DRAIN_TIMEOUT(255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .layer_id    (layer_id),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .param_req   (param_req),
        .param_layer (param_layer),
        .param_ack   (param_ack),
        .fm_rd_en    (fm_rd_en),
        .fm_rd_addr  (fm_rd_addr),
        .fm_rd_data  (fm_rd_data),
        .pc_input_vld(pc_input_vld),
        .pc_input_din(pc_input_din),
        .pc_dout_vld (pc_dout_vld),
        .pc_dout     (pc_dout),
        .ob_wr_en    (ob_wr_en),
        .ob_wr_addr  (ob_wr_addr),
        .ob_wr_data  (ob_wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] ram_word(input int a);
        logic [15:0] v;
        v = 16'(a);
        return {v ^ 16'hA5A5, v + 16'h1000, 16'(a * 3)};
    endfunction

    function automatic logic [511:0] res_word(input int i);
        logic [511:0] w;
        for (int c = 0; c < 32; c++) w[c*16 +: 16] = 16'(i * 37 + c);
        return w;
    endfunction

    function automatic int rd_bad();
        int b = 0;
        if (rd_q.size() != TOTAL) b++;
        foreach (rd_q[i]) if (rd_q[i] != i) b++;
        return b;
    endfunction

    function automatic int wr_bad();
        int b = 0;
        foreach (wa_q[i]) begin
            if (wa_q[i] != i) b++;
            if (wd_q[i] !== res_word(i)) b++;
        end
        return b;
    endfunction

    // monitor, feature-map RAM and array model, all on the falling edge
    initial forever begin
        @(negedge clk);
        if (fm_rd_en) rd_q.push_back(int'(fm_rd_addr));
        if (pc_input_vld) begin
            if (!prev_vld) in_runs++;
            if (pc_input_din !== ram_word(in_idx)) in_bad++;
        end
        prev_vld = pc_input_vld;
        if (ob_wr_en) begin
            wa_q.push_back(int'(ob_wr_addr));
            wd_q.push_back(ob_wr_data);
        end
        if (done) done_cnt++;
        fm_rd_data = fm_rd_en ? ram_word(int'(fm_rd_addr)) : '0;
        if (pipe_v[3]) begin
            if (!(mode == 2 && pipe_idx[3] == TOTAL - 1)) rq.push_back(pipe_idx[3]);
            if (mode == 3 && pipe_idx[3] == TOTAL - 1) rq.push_back(TOTAL);
        end
        for (int i = 3; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_idx[i] = pipe_idx[i-1];
        end
        pipe_v[0] = pc_input_vld;
        pipe_idx[0] = in_idx;
        if (pc_input_vld) in_idx++;
        pc_dout_vld = 1'b0;
        if (rq.size() > 0) begin
            if (mode != 1 || gap_ph == 0) begin
                pc_dout_vld = 1'b1;
                pc_dout = res_word(rq.pop_front());
            end
            gap_ph = (gap_ph == 2) ? 0 : gap_ph + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        rq.delete();
        in_idx = 0;
        in_runs = 0;
        in_bad = 0;
        done_cnt = 0;
        gap_ph = 0;
        prev_vld = 1'b0;
        pc_dout_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_idx[i] = 0;
        end
    endtask

    task automatic pulse_start(input logic [3:0] id);
        layer_id = id;
        start = 1'b1;
        tick();
        start = 1'b0;
        layer_id = '0;
    endtask

    task automatic ack_after(input int d);
        repeat (d - 1) tick();
        param_ack = 1'b1;
        tick();
        param_ack = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({busy, done, err, param_req, fm_rd_en, pc_input_vld, ob_wr_en} !== 7'b0)
            begin bad++; $display("FAIL reset_flags: got %b required 0000000",
                {busy, done, err, param_req, fm_rd_en, pc_input_vld, ob_wr_en}); end
        total++;
        if (param_layer !== 4'd0)
            begin bad++; $display("FAIL reset_param_layer: got %0d required 0", param_layer); end
        total++;
        if (fm_rd_addr !== 10'd0)
            begin bad++; $display("FAIL reset_rd_addr: got %0d required 0", fm_rd_addr); end
        total++;
        if (ob_wr_addr !== 10'd0 || ob_wr_data !== '0)
            begin bad++; $display("FAIL reset_wr_bus: addr=%0d required 0", ob_wr_addr); end
    endtask

    task automatic test_nominal();
        clear_logs();
        mode = 0;
        pulse_start(4'd5);
        total++;
        if (param_req !== 1'b1 || param_layer !== 4'd5)
            begin bad++; $display("FAIL nom_param: req=%b layer=%0d required 1/5", param_req, param_layer); end
        ack_after(3);
        total++;
        if (param_req !== 1'b0 || fm_rd_en !== 1'b1 || fm_rd_addr !== 10'd0)
            begin bad++; $display("FAIL nom_stream_entry: req=%b en=%b addr=%0d required 0/1/0",
                param_req, fm_rd_en, fm_rd_addr); end
        wait_idle(300);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL nom_timeout: busy=%b required 0", busy); end
        total++;
        if (rd_bad() !== 0)
            begin bad++; $display("FAIL nom_reads: %0d reads, %0d bad, required 36/0", rd_q.size(), rd_bad()); end
        total++;
        if (in_idx !== TOTAL || in_runs !== 1 || in_bad !== 0)
            begin bad++; $display("FAIL nom_inputs: vld=%0d runs=%0d bad=%0d required 36/1/0",
                in_idx, in_runs, in_bad); end
        total++;
        if (wa_q.size() !== TOTAL || wr_bad() !== 0)
            begin bad++; $display("FAIL nom_writes: %0d writes, %0d bad, required 36/0", wa_q.size(), wr_bad()); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL nom_done: pulses=%0d required 1", done_cnt); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL nom_err: err=%b required 0", err); end
    endtask

    task automatic test_gaps();
        clear_logs();
        mode = 1;
        pulse_start(4'd2);
        ack_after(3);
        wait_idle(400);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL gap_timeout: busy=%b required 0", busy); end
        total++;
        if (wa_q.size() !== TOTAL || wr_bad() !== 0)
            begin bad++; $display("FAIL gap_writes: %0d writes, %0d bad, required 36/0", wa_q.size(), wr_bad()); end
        total++;
        if (done_cnt !== 1 || err !== 1'b0)
            begin bad++; $display("FAIL gap_done_err: done=%0d err=%b required 1/0", done_cnt, err); end
    endtask

    task automatic test_missing();
        clear_logs();
        mode = 2;
        pulse_start(4'd3);
        ack_after(3);
        wait_idle(600);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL miss_timeout: busy=%b required 0", busy); end
        total++;
        if (err !== 1'b1 || done_cnt !== 1)
            begin bad++; $display("FAIL miss_err_done: err=%b done=%0d required 1/1", err, done_cnt); end
        total++;
        if (wa_q.size() !== TOTAL - 1 || wa_q[$] !== TOTAL - 2 || wr_bad() !== 0)
            begin bad++; $display("FAIL miss_writes: %0d writes, last=%0d required 35/34", wa_q.size(), wa_q[$]); end
    endtask

    task automatic test_extra();
        clear_logs();
        mode = 3;
        pulse_start(4'd4);
        ack_after(3);
        wait_idle(300);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL extra_timeout: busy=%b required 0", busy); end
        total++;
        if (wa_q.size() !== TOTAL || wr_bad() !== 0)
            begin bad++; $display("FAIL extra_writes: %0d writes, %0d bad, required 36/0", wa_q.size(), wr_bad()); end
        total++;
        if (err !== 1'b1 || done_cnt !== 1)
            begin bad++; $display("FAIL extra_err_done: err=%b done=%0d required 1/1", err, done_cnt); end
    endtask

    task automatic test_abort();
        int nw;
        clear_logs();
        mode = 0;
        pulse_start(4'd1);
        ack_after(3);
        repeat (9) tick();
        total++;
        if (fm_rd_addr !== 10'd9 || fm_rd_en !== 1'b1)
            begin bad++; $display("FAIL abort_pos: addr=%0d en=%b required 9/1", fm_rd_addr, fm_rd_en); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nw = wa_q.size();
        total++;
        if ({busy, fm_rd_en, ob_wr_en} !== 3'b000)
            begin bad++; $display("FAIL abort_stop: busy/en/wr=%b required 000", {busy, fm_rd_en, ob_wr_en}); end
        total++;
        if (pc_input_vld !== 1'b1)
            begin bad++; $display("FAIL abort_inflight: vld=%b required 1", pc_input_vld); end
        repeat (20) tick();
        total++;
        if (wa_q.size() !== nw || done_cnt !== 0 || busy !== 1'b0)
            begin bad++; $display("FAIL abort_quiet: writes=%0d/%0d done=%0d required no change/0",
                wa_q.size(), nw, done_cnt); end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL abort_stray: err=%b required 1", err); end
        clear_logs();
        pulse_start(4'd6);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL restart_clr: err=%b required 0", err); end
        ack_after(3);
        wait_idle(300);
        total++;
        if (rd_bad() !== 0 || wa_q.size() !== TOTAL || wr_bad() !== 0)
            begin bad++; $display("FAIL restart_run: reads=%0d writes=%0d required 36/36", rd_q.size(), wa_q.size()); end
        total++;
        if (err !== 1'b0 || done_cnt !== 1 || busy !== 1'b0)
            begin bad++; $display("FAIL restart_end: err=%b done=%0d required 0/1", err, done_cnt); end
    endtask

    task automatic test_async_reset();
        clear_logs();
        mode = 0;
        pulse_start(4'd7);
        ack_after(3);
        repeat (TOTAL) tick();
        total++;
        if (busy !== 1'b1 || fm_rd_en !== 1'b0)
            begin bad++; $display("FAIL ar_drain: busy=%b en=%b required 1/0", busy, fm_rd_en); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, param_req, fm_rd_en, pc_input_vld, ob_wr_en} !== 7'b0)
            begin bad++; $display("FAIL ar_flags: got %b required 0000000",
                {busy, done, err, param_req, fm_rd_en, pc_input_vld, ob_wr_en}); end
        total++;
        if (fm_rd_addr !== 10'd0 || ob_wr_addr !== 10'd0 || ob_wr_data !== '0 || param_layer !== 4'd0)
            begin bad++; $display("FAIL ar_buses: rd=%0d wr=%0d layer=%0d required 0", fm_rd_addr, ob_wr_addr, param_layer); end
        clear_logs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (done_cnt !== 0 || busy !== 1'b0)
            begin bad++; $display("FAIL ar_nodone: done=%0d busy=%b required 0/0", done_cnt, busy); end
        clear_logs();
        pulse_start(4'd7);
        layer_id = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        layer_id = '0;
        total++;
        if (param_layer !== 4'd7 || param_req !== 1'b1)
            begin bad++; $display("FAIL param_start_ignored: layer=%0d req=%b required 7/1", param_layer, param_req); end
        ack_after(3);
        wait_idle(300);
        total++;
        if (done_cnt !== 1 || err !== 1'b0 || wa_q.size() !== TOTAL || wr_bad() !== 0)
            begin bad++; $display("FAIL ar_rerun: done=%0d err=%b writes=%0d required 1/0/36",
                done_cnt, err, wa_q.size()); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_missing();
        test_extra();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pconv_sched.md
Name: pconv_sched

Overview:
- Layer scheduler for the pointwise-convolution array.
- On `start`, it requests the layer's weight/bias/shift set and waits for it to be loaded.
- It then streams every pixel of an INPUT_SIZE x INPUT_SIZE feature map from the input buffer into the array. Each array result is written to the output buffer at a sequential address.
- It finishes with a done pulse, or flags an error if results go missing or extra results appear.
- Sits between the layer sequencer, the feature-map/output RAMs and the pconv array.

Parameters:
- N, 16, data bit width per channel.
- INPUT_CHANNEL, 3, channels per input pixel.
- OUTPUT_CHANNEL, 32, channels per output pixel.
- INPUT_SIZE, 6, feature-map side; TOTAL = INPUT_SIZE*INPUT_SIZE pixels.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= TOTAL.
- LAYER_W, 4, layer id width.
- DRAIN_TIMEOUT, 255, maximum idle cycles between results in DRAIN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to run a layer; honoured only in IDLE.
- abort  in  1  synchronous abort, returns the block to IDLE.
- layer_id  in  LAYER_W  layer to run; sampled on an accepted start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky error flag; cleared by the next accepted start.
- param_req  out  1  parameter-load request.
- param_layer  out  LAYER_W  layer whose parameters are requested.
- param_ack  in  1  parameters are loaded into the array.
- fm_rd_en  out  1  feature-map RAM read enable.
- fm_rd_addr  out  ADDR_W  feature-map RAM read address.
- fm_rd_data  in  INPUT_CHANNEL*N  RAM read data, valid one cycle after fm_rd_en.
- pc_input_vld  out  1  input valid to the array.
- pc_input_din  out  INPUT_CHANNEL*N  input pixel to the array.
- pc_dout_vld  in  1  array result valid.
- pc_dout  in  OUTPUT_CHANNEL*N  array result.
- ob_wr_en  out  1  output buffer write enable.
- ob_wr_addr  out  ADDR_W  output buffer write address.
- ob_wr_data  out  OUTPUT_CHANNEL*N  output buffer write data.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE.
- States: IDLE, PARAM, STREAM, DRAIN, DONE.
- IDLE: on start, latch layer_id, clear err and counters, go to PARAM. Start is ignored in every other state.
- PARAM: param_req=1 and param_layer = latched id, held until param_ack is sampled high.
  - On that cycle param_req drops to 0 and the state goes to STREAM.
  - param_ack outside PARAM is ignored.
- STREAM: fm_rd_en=1 every cycle, with fm_rd_addr = rd_cnt incrementing 0..TOTAL-1.
  - After the cycle issuing address TOTAL-1, go to DRAIN.
- Array input timing:
  - pc_input_vld is fm_rd_en delayed one cycle (registered).
  - pc_input_din = fm_rd_data in the same cycle (pass-through).
  - Exactly TOTAL input_vld cycles per run, with no gaps.
- Result capture, in STREAM or DRAIN, on pc_dout_vld=1 while wr_cnt < TOTAL:
  - Next cycle: ob_wr_en=1, ob_wr_addr=wr_cnt, ob_wr_data=pc_dout (registered, latency 1).
  - wr_cnt increments.
- Extra result: pc_dout_vld when wr_cnt == TOTAL gives no write and sets err.
- Results arriving while still in STREAM are legal and captured normally.
- DRAIN completion:
  - When wr_cnt reaches TOTAL, go to DONE.
  - An idle counter resets on each pc_dout_vld and otherwise increments.
  - When the idle counter reaches DRAIN_TIMEOUT: set err, go to DONE.
- DONE: done=1 for one cycle, then IDLE. pc_dout_vld in DONE/IDLE sets err (stray result); err stays set after done.
- abort in any non-IDLE state:
  - Next cycle: state IDLE, fm_rd_en=0, param_req=0, no further writes, done not pulsed, err unchanged.
  - A pc_input_vld already in flight still issues that cycle.
  - abort has priority over start in the same cycle.
- Asynchronous reset mid-run clears everything immediately; no done pulse.
- Counter widths: ADDR_W+1 bits for rd_cnt/wr_cnt, 8 bits minimum for the idle counter.

Decomposition:
- Shared package nn_pkg holds:
  - state encoding localparams (IDLE=0, PARAM=1, STREAM=2, DRAIN=3, DONE=4);
  - TOTAL computation;
  - the clog2 function.
- One natural sub-module: pconv_sched_wr. It holds the write-back register stage, the wr_cnt counter, the idle/timeout counter and the extra/stray-result error detection. The top level keeps the FSM and read side.

Test Plan:
- Nominal run (INPUT_SIZE=6), ack after 3 cycles, array latency 4 cycles: 36 reads at addresses 0..35, 36 contiguous pc_input_vld cycles, 36 writes at addresses 0..35 with data matching each pc_dout; done pulses once; err=0.
- Result gaps: pc_dout_vld toggles 1,0,0,1 during DRAIN → writes stay in address order, done is reached, no err.
- Missing last result: only 35 results returned → after 255 idle cycles err=1, done pulses, last write address is 34.
- Extra result: a 37th pc_dout_vld is injected before DONE → no write to address 36; err=1.
- abort in the 10th STREAM cycle: fm_rd_en=0 the next cycle, busy=0, no done pulse. A following start runs cleanly from address 0 with err cleared.
- Async reset: rst_n is asserted mid-DRAIN → all outputs are 0 immediately; start during PARAM is ignored (param_layer unchanged).
